// File: rtl/mem_req_arbiter.sv
// Shares the memory-controller request port between fetch, LSB loads and committed stores.
// Priority store > load > fetch, with a starvation override for fetch and read squashing on flush.
module mem_req_arbiter #(
   parameter int STARVE_LIMIT = 16,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              flush,
   // Each *_req is held with its payload stable until its 1-cycle *_done pulse; mem_valid is
   // held with mem_* stable until the 1-cycle mem_done; nothing is granted in the cycle after a done.
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_done,
   input  logic              load_req,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [2:0]        load_size,
   input  logic              load_sign,
   output logic              load_done,
   input  logic              store_req,
   input  logic [ADDR_W-1:0] store_addr,
   input  logic [2:0]        store_size,
   input  logic [31:0]       store_data,
   output logic              store_done,
   output logic [31:0]       rdata,
   output logic              mem_valid,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_size,
   output logic              mem_sign,
   output logic [31:0]       mem_wdata,
   input  logic              mem_done,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DRAIN = 2'd2, S_COOL = 2'd3} state_t;

   localparam logic [1:0] OWN_FETCH = 2'd0;
   localparam logic [1:0] OWN_LOAD  = 2'd1;
   localparam logic [1:0] OWN_STORE = 2'd2;
   localparam int         CNT_W     = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   state_t            r_state, w_state_nxt;
   logic [1:0]        r_owner;
   logic [CNT_W-1:0]  r_starve;
   logic              r_fetch_done, r_load_done, r_store_done;
   logic              r_mem_valid, r_mem_write, r_mem_sign;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [2:0]        r_mem_size;
   logic [31:0]       r_mem_wdata, r_rdata;

   logic w_starved, w_load_ok, w_can_grant;
   logic w_grant_fetch, w_grant_load, w_grant_store, w_grant;
   logic w_owner_read, w_retire, w_complete;

   always_ff @(posedge clk) begin
      if (rst)      r_state <= S_IDLE;
      else if (rdy) r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_state_nxt = S_BUSY;
         S_BUSY:  if (mem_done) w_state_nxt = S_COOL;
                  else if (flush && w_owner_read) w_state_nxt = S_DRAIN;
         S_DRAIN: if (mem_done) w_state_nxt = S_COOL;
         S_COOL:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // IO-space loads (addr[17:16]==2'b11) must not overtake a pending store to keep UART order.
   always_comb begin
      w_starved     = fetch_req && (r_starve == STARVE_MAX);
      w_load_ok     = load_req && !(store_req && (load_addr[17:16] == 2'b11));
      w_can_grant   = (r_state == S_IDLE) && !flush;
      w_grant_store = w_can_grant && store_req && !w_starved;
      w_grant_load  = w_can_grant && w_load_ok && !store_req && !w_starved;
      w_grant_fetch = w_can_grant && fetch_req && (w_starved || (!store_req && !w_load_ok));
      w_grant       = w_grant_store || w_grant_load || w_grant_fetch;
      w_owner_read  = (r_owner != OWN_STORE);
      w_retire      = mem_done && ((r_state == S_BUSY) || (r_state == S_DRAIN));
      w_complete    = mem_done && (r_state == S_BUSY) && !(flush && w_owner_read);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner      <= OWN_FETCH;
         r_starve     <= '0;
         r_fetch_done <= 1'b0;
         r_load_done  <= 1'b0;
         r_store_done <= 1'b0;
         r_mem_valid  <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_sign   <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_size   <= '0;
         r_mem_wdata  <= '0;
         r_rdata      <= '0;
      end else if (rdy) begin
         r_fetch_done <= w_complete && (r_owner == OWN_FETCH);
         r_load_done  <= w_complete && (r_owner == OWN_LOAD);
         r_store_done <= w_complete && (r_owner == OWN_STORE);
         if (w_complete && w_owner_read) r_rdata <= mem_rdata;
         if (w_grant) begin
            r_mem_valid <= 1'b1;
            if (w_grant_store) begin
               r_owner     <= OWN_STORE;
               r_mem_write <= 1'b1;
               r_mem_addr  <= store_addr;
               r_mem_size  <= store_size;
               r_mem_sign  <= 1'b0;
               r_mem_wdata <= store_data;
            end else if (w_grant_load) begin
               r_owner     <= OWN_LOAD;
               r_mem_write <= 1'b0;
               r_mem_addr  <= load_addr;
               r_mem_size  <= load_size;
               r_mem_sign  <= load_sign;
               r_mem_wdata <= '0;
            end else begin
               r_owner     <= OWN_FETCH;
               r_mem_write <= 1'b0;
               r_mem_addr  <= fetch_addr;
               r_mem_size  <= 3'd4;
               r_mem_sign  <= 1'b0;
               r_mem_wdata <= '0;
            end
         end else if (w_retire) begin
            r_mem_valid <= 1'b0;
         end
         // Waiting accrues on every cycle fetch asks without winning, including its own service.
         if (flush || w_grant_fetch)
            r_starve <= '0;
         else if (fetch_req && (r_starve != STARVE_MAX))
            r_starve <= r_starve + 1'b1;
      end
   end

   assign fetch_done = r_fetch_done;
   assign load_done  = r_load_done;
   assign store_done = r_store_done;
   assign rdata      = r_rdata;
   assign mem_valid  = r_mem_valid;
   assign mem_write  = r_mem_write;
   assign mem_addr   = r_mem_addr;
   assign mem_size   = r_mem_size;
   assign mem_sign   = r_mem_sign;
   assign mem_wdata  = r_mem_wdata;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a transaction-level model checked every cycle plus literal checks.
`timescale 1ns/1ps
module tb_mem_req_arbiter;

   localparam int LIMIT  = 4;
   localparam int O_NONE = 0;
   localparam int O_FETCH = 1;
   localparam int O_LOAD  = 2;
   localparam int O_STORE = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   logic        fetch_req = 1'b0;
   logic [31:0] fetch_addr = '0;
   logic        fetch_done;
   logic        load_req = 1'b0;
   logic [31:0] load_addr = '0;
   logic [2:0]  load_size = 3'd4;
   logic        load_sign = 1'b0;
   logic        load_done;
   logic        store_req = 1'b0;
   logic [31:0] store_addr = '0;
   logic [2:0]  store_size = 3'd4;
   logic [31:0] store_data = '0;
   logic        store_done;
   logic [31:0] rdata;
   logic        mem_valid, mem_write, mem_sign;
   logic [31:0] mem_addr, mem_wdata;
   logic [2:0]  mem_size;
   logic        mem_done = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [1:0]  dbg_state;

   mem_req_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
      .load_req(load_req), .load_addr(load_addr), .load_size(load_size),
      .load_sign(load_sign), .load_done(load_done),
      .store_req(store_req), .store_addr(store_addr), .store_size(store_size),
      .store_data(store_data), .store_done(store_done),
      .rdata(rdata), .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_size(mem_size), .mem_sign(mem_sign), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [31:0] exp_q[$];
   int g_cyc[$];
   bit prev_valid = 1'b0;
   bit hold_store = 1'b0;
   bit auto_resp  = 1'b0;
   int resp_lat   = 0;
   int resp_cnt   = 0;

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit          m_init = 1'b0;
   int          m_owner = O_NONE;
   bit          m_squashed = 1'b0;
   bit          m_cool = 1'b0;
   int          m_starve = 0;
   logic        m_valid, m_write, m_sign, m_fd, m_ld, m_sd;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [2:0]  m_size;

   task automatic model_issue(input int who, input logic [31:0] a, input logic [2:0] sz,
                              input logic sg, input logic [31:0] wd);
      m_owner = who;
      m_valid = 1'b1;
      m_write = (who == O_STORE);
      m_addr  = a;
      m_size  = sz;
      m_sign  = sg;
      m_wdata = wd;
   endtask

   task automatic model_step();
      bit fetch_won;
      bit is_read;
      bit io_blocked;
      fetch_won = 1'b0;
      if (rst) begin
         m_init = 1'b1; m_owner = O_NONE; m_squashed = 1'b0; m_cool = 1'b0; m_starve = 0;
         m_valid = 0; m_write = 0; m_sign = 0; m_fd = 0; m_ld = 0; m_sd = 0;
         m_addr = '0; m_wdata = '0; m_rdata = '0; m_size = '0;
      end else if (rdy) begin
         m_fd = 1'b0; m_ld = 1'b0; m_sd = 1'b0;
         if (m_cool) begin
            m_cool = 1'b0;
         end else if (m_owner == O_NONE) begin
            io_blocked = store_req && (load_addr[17:16] == 2'b11);
            if (!flush) begin
               if (fetch_req && m_starve == LIMIT)      fetch_won = 1'b1;
               else if (store_req)                      model_issue(O_STORE, store_addr, store_size, 1'b0, store_data);
               else if (load_req && !io_blocked)        model_issue(O_LOAD, load_addr, load_size, load_sign, '0);
               else if (fetch_req)                      fetch_won = 1'b1;
               if (fetch_won) model_issue(O_FETCH, fetch_addr, 3'd4, 1'b0, '0);
            end
         end else begin
            is_read = (m_owner != O_STORE);
            if (mem_done) begin
               if (!m_squashed && !(flush && is_read)) begin
                  m_fd = (m_owner == O_FETCH);
                  m_ld = (m_owner == O_LOAD);
                  m_sd = (m_owner == O_STORE);
                  if (is_read) m_rdata = mem_rdata;
               end
               m_valid = 1'b0; m_owner = O_NONE; m_squashed = 1'b0; m_cool = 1'b1;
            end else if (flush && is_read) begin
               m_squashed = 1'b1;
            end
         end
         if (flush || fetch_won)                m_starve = 0;
         else if (fetch_req && m_starve < LIMIT) m_starve++;
      end
   endtask

   // Observable phase: 0 idle, 1 serving, 2 squashed read in flight, 3 cool-down.
   function automatic logic [1:0] model_phase();
      if (m_cool)             return 2'd3;
      if (m_owner == O_NONE)  return 2'd0;
      if (m_squashed)         return 2'd2;
      return 2'd1;
   endfunction

   task automatic compare();
      if (m_init) begin
         check1("fetch_done", fetch_done, m_fd);
         check1("load_done", load_done, m_ld);
         check1("store_done", store_done, m_sd);
         check32("rdata", rdata, m_rdata);
         check1("mem_valid", mem_valid, m_valid);
         check32("state", 32'(dbg_state), 32'(model_phase()));
         if (m_valid) begin
            check1("mem_write", mem_write, m_write);
            check32("mem_addr", mem_addr, m_addr);
            check32("mem_size", 32'(mem_size), 32'(m_size));
            if (m_write) check32("mem_wdata", mem_wdata, m_wdata);
            else         check1("mem_sign", mem_sign, m_sign);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      logic [31:0] want;
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      compare();
      if (mem_valid && !prev_valid) begin
         g_cyc.push_back(cyc);
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check32("grant_addr", mem_addr, want);
         end
      end
      prev_valid = mem_valid;
      if (fetch_done) fetch_req = 1'b0;
      if (load_done)  load_req  = 1'b0;
      if (store_done) begin
         if (hold_store) store_addr = store_addr + 32'd4;
         else            store_req  = 1'b0;
      end
      if (mem_done) begin
         mem_done = 1'b0;
      end else if (auto_resp && mem_valid) begin
         if (resp_cnt >= resp_lat) begin
            mem_done  = 1'b1;
            mem_rdata = mem_addr + 32'h13;
            resp_cnt  = 0;
         end else begin
            resp_cnt++;
         end
      end
   endtask

   // Leaves rst asserted so the caller can set up requests before releasing it.
   task automatic do_reset();
      rst = 1'b1; rdy = 1'b1; flush = 1'b0;
      fetch_req = 0; load_req = 0; store_req = 0; mem_done = 0;
      hold_store = 0; auto_resp = 0; resp_lat = 0;
      tick();
      tick();
      resp_cnt = 0;
      exp_q.delete();
      g_cyc.delete();
   endtask

   task automatic run_until_quiet(input string name, input int budget);
      int k;
      k = 0;
      while ((fetch_req || load_req || store_req || mem_valid) && (k < budget)) begin
         tick();
         k++;
      end
      check1({name, "_timeout"}, k < budget, 1'b1);
      tick();
      tick();
      check32({name, "_grants_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- directed tests ----------------
   initial begin : stim
      int k;
      int sd_cnt;

      // 1: first fetch after reset
      do_reset();
      check1("rst_mem_valid", mem_valid, 1'b0);
      check1("rst_fetch_done", fetch_done, 1'b0);
      check32("rst_rdata", rdata, 32'h0);
      check32("rst_state", 32'(dbg_state), 32'd0);
      fetch_req = 1; fetch_addr = 32'h0;
      auto_resp = 1; resp_lat = 0;
      rst = 0;
      tick();
      check1("t1_valid", mem_valid, 1'b1);
      check32("t1_addr", mem_addr, 32'h0);
      check32("t1_size", 32'(mem_size), 32'd4);
      check1("t1_write", mem_write, 1'b0);
      tick();
      check1("t1_done", fetch_done, 1'b1);
      check32("t1_rdata", rdata, 32'h13);
      check1("t1_valid_drop", mem_valid, 1'b0);
      tick();
      check1("t1_done_pulse", fetch_done, 1'b0);
      run_until_quiet("t1", 20);

      // 2: all three request at once
      do_reset();
      fetch_addr = 32'h100; fetch_req = 1;
      load_addr = 32'h2000; load_size = 3'd2; load_sign = 1; load_req = 1;
      store_addr = 32'h3000; store_size = 3'd1; store_data = 32'hAB; store_req = 1;
      auto_resp = 1; resp_lat = 0;
      exp_q.push_back(32'h3000); exp_q.push_back(32'h2000); exp_q.push_back(32'h100);
      rst = 0;
      run_until_quiet("t2", 60);
      check32("t2_grants", 32'(g_cyc.size()), 32'd3);
      if (g_cyc.size() == 3) begin
         check32("t2_gap1", 32'(g_cyc[1] - g_cyc[0]), 32'd3);
         check32("t2_gap2", 32'(g_cyc[2] - g_cyc[1]), 32'd3);
      end

      // 3: fetch starvation under back-to-back stores
      do_reset();
      fetch_addr = 32'h400; fetch_req = 1;
      store_addr = 32'h5000; store_size = 3'd4; store_data = 32'hCAFE_F00D; store_req = 1;
      hold_store = 1; auto_resp = 1; resp_lat = 2;
      exp_q.push_back(32'h5000); exp_q.push_back(32'h400); exp_q.push_back(32'h5004);
      rst = 0;
      k = 0;
      while (!fetch_done && k < 40) begin
         tick();
         k++;
      end
      check1("t3_fetch_served", fetch_done, 1'b1);
      hold_store = 0;
      run_until_quiet("t3", 60);
      if (g_cyc.size() >= 2) check32("t3_starve_gap", 32'(g_cyc[1] - g_cyc[0]), 32'd5);

      // 4: IO load waits for the store; ordinary load in the same situation
      do_reset();
      store_addr = 32'h6000; store_data = 32'h11; store_req = 1;
      load_addr = 32'h0003_0000; load_size = 3'd4; load_sign = 0; load_req = 1;
      auto_resp = 1; resp_lat = 1;
      exp_q.push_back(32'h6000); exp_q.push_back(32'h0003_0000);
      rst = 0;
      run_until_quiet("t4_io", 40);
      do_reset();
      store_addr = 32'h6100; store_data = 32'h22; store_req = 1;
      load_addr = 32'h1000; load_size = 3'd1; load_sign = 1; load_req = 1;
      auto_resp = 1; resp_lat = 1;
      exp_q.push_back(32'h6100); exp_q.push_back(32'h1000);
      rst = 0;
      run_until_quiet("t4_mem", 40);

      // 5a: flush during a fetch -> drain, no done
      do_reset();
      fetch_addr = 32'h800; fetch_req = 1;
      rst = 0;
      tick();
      check1("t5_valid", mem_valid, 1'b1);
      tick();
      flush = 1; fetch_req = 0;
      tick();
      flush = 0;
      check32("t5_drain", 32'(dbg_state), 32'd2);
      check1("t5_drain_valid", mem_valid, 1'b1);
      tick();
      mem_done = 1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      check1("t5_no_done", fetch_done, 1'b0);
      check1("t5_valid_drop", mem_valid, 1'b0);
      check32("t5_rdata_kept", rdata, 32'h0);
      tick();
      check1("t5_no_done2", fetch_done, 1'b0);
      run_until_quiet("t5a", 10);

      // 5b: flush during a store -> store still completes
      do_reset();
      store_addr = 32'h7000; store_data = 32'h5A5A_5A5A; store_size = 3'd4; store_req = 1;
      auto_resp = 1; resp_lat = 2;
      rst = 0;
      tick();
      flush = 1;
      tick();
      flush = 0;
      sd_cnt = 0;
      repeat (8) begin
         tick();
         if (store_done) sd_cnt++;
      end
      check32("t5_store_done_cnt", 32'(sd_cnt), 32'd1);
      run_until_quiet("t5b", 10);

      // 5c: flush and mem_done together on a load
      do_reset();
      load_addr = 32'h900; load_size = 3'd4; load_sign = 0; load_req = 1;
      rst = 0;
      tick();
      flush = 1; mem_done = 1; mem_rdata = 32'h1234_5678; load_req = 0;
      tick();
      flush = 0;
      check1("t5c_no_done", load_done, 1'b0);
      check32("t5c_cool", 32'(dbg_state), 32'd3);
      check32("t5c_rdata_kept", rdata, 32'h0);
      run_until_quiet("t5c", 10);

      // 6: rdy low mid-BUSY freezes everything
      do_reset();
      load_addr = 32'hA000; load_size = 3'd2; load_sign = 1; load_req = 1;
      rst = 0;
      tick();
      tick();
      rdy = 0;
      repeat (3) begin
         tick();
         check1("t6_hold_valid", mem_valid, 1'b1);
         check32("t6_hold_addr", mem_addr, 32'hA000);
         check32("t6_hold_state", 32'(dbg_state), 32'd1);
      end
      rdy = 1;
      mem_done = 1; mem_rdata = 32'hFFFF_8001;
      tick();
      check1("t6_done", load_done, 1'b1);
      check32("t6_rdata", rdata, 32'hFFFF_8001);
      run_until_quiet("t6", 10);

      // 7: reset mid-transaction, late mem_done ignored
      do_reset();
      load_addr = 32'hB000; load_req = 1;
      rst = 0;
      tick();
      tick();
      rst = 1; load_req = 0;
      tick();
      rst = 0;
      check1("t7_valid_cleared", mem_valid, 1'b0);
      check32("t7_idle", 32'(dbg_state), 32'd0);
      mem_done = 1; mem_rdata = 32'h55;
      tick();
      check1("t7_no_done", load_done, 1'b0);
      check32("t7_rdata", rdata, 32'h0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
